// File: rtl/neuron_mac.sv
// Single-neuron MAC: streams N_INPUTS signed 8x8 products into a biased accumulator,
// then requantises (>>> SHIFT) and saturates to signed 8 bits for the ReLU stage.
module neuron_mac #(
  parameter int N_INPUTS = 8,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] bias,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic [7:0]  w_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy
);
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic [CNT_W-1:0] N_CNT = CNT_W'(N_INPUTS);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-128);

  typedef enum logic [2:0] {IDLE, ACC, DRAIN, SCALE, OUT} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] t;
  logic signed [15:0]      prod_r;
  logic                    prod_v;
  logic                    beat;
  logic                    last_beat;
  logic [7:0]              sat;

  assign beat      = in_valid & in_ready;
  assign last_beat = beat && (cnt == N_CNT - 1'b1);
  assign busy      = (state != IDLE);

  // Product registered one beat earlier is folded in here: multiply/add pipelined one deep.
  assign acc_sum = prod_v ? acc + {{(ACC_W-16){prod_r[15]}}, prod_r} : acc;

  assign t   = acc >>> SHIFT;
  assign sat = (t > SAT_HI) ? 8'h7F :
               (t < SAT_LO) ? 8'h80 : t[7:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = ACC;
      ACC: begin
        in_ready = (cnt < N_CNT);
        if (last_beat) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = SCALE;
      SCALE: state_nxt = OUT;
      OUT:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      prod_r    <= '0;
      prod_v    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc    <= {{(ACC_W-16){bias[15]}}, bias};
            cnt    <= '0;
            prod_v <= 1'b0;
          end
        end
        ACC: begin
          acc    <= acc_sum;
          prod_v <= beat;
          if (beat) begin
            prod_r <= $signed(in_data) * $signed(w_data);
            cnt    <= cnt + 1'b1;
          end
        end
        DRAIN: begin
          acc    <= acc_sum;
          prod_v <= 1'b0;
        end
        SCALE: begin
          out_data  <= sat;
          out_valid <= 1'b1;
        end
        OUT: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: SHIFT=0 and SHIFT=4 instances run in lockstep on shared stimulus,
// table vectors + hand sequences + random evaluations against an arithmetic model.
module tb_neuron_mac;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, in_valid, out_ready;
  logic [15:0] bias;
  logic [7:0]  in_data, w_data;
  logic        in_ready0, out_valid0, busy0;
  logic        in_ready4, out_valid4, busy4;
  logic signed [7:0] out_data0, out_data4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  neuron_mac #(.N_INPUTS(4), .ACC_W(24), .SHIFT(0)) u_s0 (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .w_data(w_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .busy(busy0));

  neuron_mac #(.N_INPUTS(4), .ACC_W(24), .SHIFT(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data), .w_data(w_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4), .busy(busy4));

  typedef struct {
    logic signed [15:0] b;
    logic [3:0][7:0]    a;
    logic [3:0][7:0]    w;
    bit                 gaps;
    int                 hold;
    logic signed [7:0]  e0;
    logic signed [7:0]  e4;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string n, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", n, act, exp);
    end
  endtask

  function automatic int model(input int b, input logic [3:0][7:0] a, input logic [3:0][7:0] w,
                               input int sh);
    int s;
    s = b;
    for (int i = 0; i < 4; i++) s += int'($signed(a[i])) * int'($signed(w[i]));
    s = s >>> sh;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic do_reset(input bit check_zero);
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    if (check_zero) begin
      chk("rst_out_valid", {out_valid0, out_valid4}, 0);
      chk("rst_in_ready", {in_ready0, in_ready4}, 0);
      chk("rst_busy", {busy0, busy4}, 0);
      chk("rst_out_data0", out_data0, 0);
      chk("rst_out_data4", out_data4, 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge with both DUTs idle (or already in ACC when skip_start).
  task automatic run_eval(input logic signed [15:0] b, input logic [3:0][7:0] a,
                          input logic [3:0][7:0] w, input bit gaps, input int hold,
                          input logic signed [7:0] e0, input logic signed [7:0] e4,
                          input bit early, input bit poke, input bit skip_start, input bit chain);
    int waited;
    logic signed [7:0] h0, h4;
    if (!skip_start) begin
      chk("idle_in_ready", {in_ready0, in_ready4}, 0);
      start = 1'b1; bias = b; out_ready = early;
      @(negedge clk);
      start = 1'b0; bias = 16'($urandom);
    end
    chk("acc_busy", {busy0, busy4}, 2'b11);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        in_valid = 1'b0; in_data = 8'($urandom); w_data = 8'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1; in_data = a[i]; w_data = w[i];
      start = poke && (i == 1);
      chk("acc_in_ready", {in_ready0, in_ready4}, 2'b11);
      @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b0;
    chk("drain_in_ready", {in_ready0, in_ready4}, 0);
    chk("drain_out_valid", {out_valid0, out_valid4}, 0);
    @(negedge clk);
    chk("scale_out_valid", {out_valid0, out_valid4}, 0);
    @(negedge clk);
    waited = 0;
    while (!(out_valid0 && out_valid4) && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    chk("latency_extra_cycles", waited, 0);
    if (!(out_valid0 && out_valid4)) begin
      do_reset(1'b0);
      return;
    end
    chk("out_data_s0", out_data0, e0);
    chk("out_data_s4", out_data4, e4);
    h0 = out_data0; h4 = out_data4;
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      start = poke && (h == 0);
      @(negedge clk);
      start = 1'b0;
      chk("hold_out_valid", {out_valid0, out_valid4}, 2'b11);
      chk("hold_data_s0", out_data0, h0);
      chk("hold_data_s4", out_data4, h4);
      chk("hold_in_ready", {in_ready0, in_ready4}, 0);
    end
    if (chain) begin
      start = 1'b1; bias = 16'sd5;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done_out_valid", {out_valid0, out_valid4}, 0);
    chk("done_busy", {busy0, busy4}, 0);
  endtask

  initial begin
    logic [3:0][7:0] ra, rw;
    logic signed [15:0] rb;

    //         bias     a (pair3..pair0)                  w (pair3..pair0)                  gaps hold  e0    e4
    tbl[0] = '{16'sd0,    {8'd2, 8'hFF, 8'd3, 8'd1},       {8'd2, 8'd5, 8'd4, 8'd2},       0, 0,  8'sd13,  8'sd0};
    tbl[1] = '{16'sd0,    {8'd2, 8'hFF, 8'd3, 8'd1},       {8'd2, 8'd5, 8'd4, 8'd2},       1, 5,  8'sd13,  8'sd0};
    tbl[2] = '{16'sd0,    {4{8'h7F}},                      {4{8'h7F}},                     0, 1,  8'sd127, 8'sd127};
    tbl[3] = '{16'sd0,    {4{8'h80}},                      {4{8'h7F}},                     0, 0, -8'sd128, -8'sd128};
    tbl[4] = '{-16'sd1,   {4{8'h00}},                      {4{8'h00}},                     0, 0, -8'sd1,  -8'sd1};
    tbl[5] = '{-16'sd17,  {4{8'h00}},                      {4{8'h00}},                     1, 2, -8'sd17, -8'sd2};
    tbl[6] = '{16'sd128,  {4{8'h00}},                      {4{8'h00}},                     0, 0,  8'sd127, 8'sd8};
    tbl[7] = '{-16'sd129, {4{8'h00}},                      {4{8'h00}},                     0, 0, -8'sd128, -8'sd9};
    tbl[8] = '{16'sd0,    {4{8'hFD}},                      {4{8'h05}},                     0, 0, -8'sd60, -8'sd4};
    tbl[9] = '{16'sd127,  {4{8'h00}},                      {4{8'h00}},                     0, 0,  8'sd127, 8'sd7};

    rst_n = 1'b0; start = 1'b0; bias = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data = '0; w_data = '0;
    #2;
    chk("init_out_valid", {out_valid0, out_valid4}, 0);
    chk("init_busy", {busy0, busy4}, 0);
    chk("init_out_data", {out_data0, out_data4}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++)
      run_eval(tbl[i].b, tbl[i].a, tbl[i].w, tbl[i].gaps, tbl[i].hold, tbl[i].e0, tbl[i].e4,
               1'b0, 1'b0, 1'b0, 1'b0);

    // out_ready high ahead of out_valid, start pulsed during ACC and OUT.
    run_eval(tbl[0].b, tbl[0].a, tbl[0].w, 1'b1, 3, 8'sd13, 8'sd0, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("no_restart_busy", {busy0, busy4}, 0);

    // start held across the OUT handshake begins the next evaluation one cycle later.
    run_eval(tbl[0].b, tbl[0].a, tbl[0].w, 1'b0, 0, 8'sd13, 8'sd0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("chain_busy", {busy0, busy4}, 2'b11);
    start = 1'b0;
    run_eval(16'sd5, tbl[0].a, tbl[0].w, 1'b0, 0, 8'sd18, 8'sd1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Abort mid-accumulation, then a clean run must show no residue.
    start = 1'b1; bias = 16'sd50;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; in_data = 8'd9; w_data = 8'd9;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    do_reset(1'b1);
    @(negedge clk);
    run_eval(16'sd100, tbl[0].a, tbl[0].w, 1'b0, 0, 8'sd113, 8'sd7, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 30; n++) begin
      rb = $urandom_range(0, 1) ? 16'($signed(10'($urandom))) : 16'($urandom);
      for (int i = 0; i < 4; i++) begin
        ra[i] = 8'($urandom);
        rw[i] = 8'($urandom);
      end
      run_eval(rb, ra, rw, 1'($urandom), int'($urandom_range(0, 3)),
               8'(model(int'(rb), ra, rw, 0)), 8'(model(int'(rb), ra, rw, 4)),
               1'($urandom), 1'b0, 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got running want finished");
    $fatal(1);
  end
endmodule
